usb_rx_controller: RTL and testbench

Receive-side sequencer for the USB bit-level decoder. It consumes decoded bits, EOP and edge indications and performs these steps:
- detects the SYNC field;
- assembles bytes LSB-first and hands them to the RX FIFO;
- flags framing, overflow and length errors;
- re-arms the decoder after each EOP, because the decoder's EOP state is sticky.
It sits between the decoder/timer pair and the RX FIFO.

---
 rtl/usb_rx_pkg.sv | 18 +
 rtl/usb_rx_controller_if.sv | 29 ++
 rtl/usb_rx_shift8.sv | 41 ++++
 rtl/usb_rx_controller.sv | 110 +++++++++++
 tb/tb_usb_rx_controller.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive sequencer.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StRecv,
        StStore,
        StEopWait,
        StDone,
        StError,
        StRearm
    } rx_state_t;

    // SYNC pattern 00000001 on the wire, seen as 8'h80 after LSB-first assembly.
    localparam logic [7:0] USB_SYNC_LSB_FIRST = 8'h80;

endpackage

// File: rtl/usb_rx_controller_if.sv
// Decoder-side inputs and FIFO-side outputs of the receive sequencer.
interface usb_rx_controller_if #(
    parameter int unsigned CNT_W = 7
);
    logic             d_edge;
    logic             d_decoded;
    logic             shift_strobe;
    logic             eop;
    logic             fifo_full;
    logic [7:0]       rx_byte;
    logic             rx_byte_valid;
    logic             rx_packet_done;
    logic             rx_error;
    logic             rcving;
    logic             decoder_rearm;
    logic [CNT_W-1:0] byte_count;

    modport slave (
        input  d_edge, d_decoded, shift_strobe, eop, fifo_full,
        output rx_byte, rx_byte_valid, rx_packet_done, rx_error, rcving, decoder_rearm,
               byte_count
    );

    modport master (
        output d_edge, d_decoded, shift_strobe, eop, fifo_full,
        input  rx_byte, rx_byte_valid, rx_packet_done, rx_error, rcving, decoder_rearm,
               byte_count
    );
endinterface

// File: rtl/usb_rx_shift8.sv
// LSB-first byte assembler: right-shift register with a 3-bit bit counter.
module usb_rx_shift8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift_i,
    input  logic       clear_i,
    input  logic       bit_i,
    output logic [7:0] next_data_o,
    output logic [2:0] bit_cnt_o,
    output logic       byte_full_o
);
    logic [7:0] data_q, data_d;
    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            data_d = 8'h00;
            cnt_d  = 3'd0;
        end else if (shift_i) begin
            data_d = {bit_i, data_q[7:1]};
            cnt_d  = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= 8'h00;
            cnt_q  <= 3'd0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    // Byte value including the bit being shifted now, so the 8th strobe can act on it.
    assign next_data_o = {bit_i, data_q[7:1]};
    assign bit_cnt_o   = cnt_q;
    assign byte_full_o = shift_i && (cnt_q == 3'd7);
endmodule

// File: rtl/usb_rx_controller.sv
// Receive sequencer: SYNC detect, byte assembly, FIFO hand-off, error flagging, decoder re-arm.
module usb_rx_controller
    import usb_rx_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = USB_SYNC_LSB_FIRST,
    parameter int unsigned MAX_BYTES = 64,
    parameter int unsigned CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input logic                clk,
    input logic                rst,
    usb_rx_controller_if.slave rx_io
);
    rx_state_t        state_q, state_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic [CNT_W-1:0] byte_count_q, byte_count_d;
    logic             rx_error_q, rx_error_d;
    logic             shift_en, clear;
    logic [7:0]       next_data;
    logic [2:0]       bit_cnt;
    logic             byte_full;

    usb_rx_shift8 u_shift8 (
        .clk         (clk),
        .rst         (rst),
        .shift_i     (shift_en),
        .clear_i     (clear),
        .bit_i       (rx_io.d_decoded),
        .next_data_o (next_data),
        .bit_cnt_o   (bit_cnt),
        .byte_full_o (byte_full)
    );

    always_comb begin
        state_d      = state_q;
        rx_byte_d    = rx_byte_q;
        byte_count_d = byte_count_q;
        rx_error_d   = rx_error_q;
        shift_en     = 1'b0;
        clear        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rx_io.d_edge) begin
                    state_d      = StSync;
                    clear        = 1'b1;
                    byte_count_d = '0;
                    rx_error_d   = 1'b0;
                end
            end
            StSync: begin
                // eop takes priority over a coincident strobe; that bit is dropped.
                if (rx_io.eop) begin
                    state_d = StError;
                end else if (rx_io.shift_strobe) begin
                    shift_en = 1'b1;
                    if (byte_full) state_d = (next_data == SYNC_BYTE) ? StRecv : StError;
                end
            end
            StRecv: begin
                if (rx_io.eop) begin
                    state_d = (bit_cnt == 3'd0) ? StDone : StError;
                end else if (rx_io.shift_strobe) begin
                    shift_en = 1'b1;
                    if (byte_full) begin
                        state_d   = StStore;
                        rx_byte_d = next_data;
                    end
                end
            end
            StStore: begin
                if (rx_io.fifo_full) begin
                    state_d = StError;
                end else begin
                    if (byte_count_q != CNT_W'(MAX_BYTES)) byte_count_d = byte_count_q + CNT_W'(1);
                    state_d = (byte_count_d == CNT_W'(MAX_BYTES)) ? StEopWait : StRecv;
                end
            end
            StEopWait: begin
                if (rx_io.eop)               state_d = StDone;
                else if (rx_io.shift_strobe) state_d = StError;
            end
            StDone:  state_d = StRearm;
            StError: if (rx_io.eop) state_d = StRearm;
            StRearm: if (!rx_io.eop) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (state_d == StError) rx_error_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            rx_byte_q    <= 8'h00;
            byte_count_q <= '0;
            rx_error_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_byte_q    <= rx_byte_d;
            byte_count_q <= byte_count_d;
            rx_error_q   <= rx_error_d;
        end
    end

    assign rx_io.rx_byte        = rx_byte_q;
    assign rx_io.rx_byte_valid  = (state_q == StStore) && !rx_io.fifo_full;
    assign rx_io.rx_packet_done = (state_q == StDone);
    assign rx_io.rx_error       = rx_error_q;
    assign rx_io.rcving         = (state_q != StIdle);
    assign rx_io.decoder_rearm  = (state_q == StRearm);
    assign rx_io.byte_count     = byte_count_q;
endmodule

// File: tb/tb_usb_rx_controller.sv
// Scoreboard bench for usb_rx_controller with a 2-byte packet limit.
module tb_usb_rx_controller;
    localparam int unsigned MaxBytes = 2;
    localparam int unsigned CntW     = $clog2(MaxBytes + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usb_rx_controller_if #(.CNT_W(CntW)) rx_if ();

    usb_rx_controller #(
        .SYNC_BYTE (8'h80),
        .MAX_BYTES (MaxBytes),
        .CNT_W     (CntW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rx_io (rx_if.slave)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned valid_cnt = 0;
    int unsigned done_cnt = 0;
    logic [7:0]  sb[$];
    logic        valid_after_strobe;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_if.rx_packet_done) done_cnt++;
        if (rx_if.rx_byte_valid) begin
            valid_cnt++;
            if (sb.size() == 0) check("spurious_byte", {31'd0, rx_if.rx_byte_valid}, 32'd0);
            else                check("rx_byte", {24'd0, rx_if.rx_byte}, {24'd0, sb.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_if.d_decoded    = b;
        rx_if.shift_strobe = 1'b1;
        tick();
        valid_after_strobe = rx_if.rx_byte_valid;
        rx_if.shift_strobe = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic start_pkt();
        rx_if.d_edge = 1'b1;
        tick();
        rx_if.d_edge = 1'b0;
        tick();
    endtask

    task automatic finish_err();
        rx_if.eop = 1'b1;
        tick();
        tick();
        rx_if.eop = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int unsigned v0, d0;
        rx_if.d_edge       = 1'b0;
        rx_if.d_decoded    = 1'b0;
        rx_if.shift_strobe = 1'b0;
        rx_if.eop          = 1'b0;
        rx_if.fifo_full    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_byte", {24'd0, rx_if.rx_byte}, 32'd0);
        check("rst_count", 32'(rx_if.byte_count), 32'd0);
        check("rst_flags", {26'd0, rx_if.rx_byte_valid, rx_if.rx_packet_done, rx_if.rx_error,
                            rx_if.rcving, rx_if.decoder_rearm, 1'b0}, 32'd0);

        // Good packet: SYNC, A5, 3C, eop after limit reached.
        start_pkt();
        check("start_rcving", {31'd0, rx_if.rcving}, 32'd1);
        send_byte(8'h80);
        sb.push_back(8'hA5);
        send_byte(8'hA5);
        check("valid_latency", {31'd0, valid_after_strobe}, 32'd1);
        rx_if.d_edge = 1'b1;
        tick();
        rx_if.d_edge = 1'b0;
        check("edge_ignored", 32'(rx_if.byte_count), 32'd1);
        sb.push_back(8'h3C);
        send_byte(8'h3C);
        check("count_two", 32'(rx_if.byte_count), 32'd2);
        rx_if.eop = 1'b1;
        tick();
        check("done_latency", {31'd0, rx_if.rx_packet_done}, 32'd1);
        tick();
        check("rearm_hold", {30'd0, rx_if.decoder_rearm, rx_if.rx_packet_done}, 32'd2);
        tick();
        check("rearm_still", {31'd0, rx_if.decoder_rearm}, 32'd1);
        rx_if.eop = 1'b0;
        tick();
        check("idle_after", {29'd0, rx_if.rcving, rx_if.decoder_rearm, rx_if.rx_error}, 32'd0);
        check("valid_cnt_1", valid_cnt, 32'd2);
        check("done_cnt_1", done_cnt, 32'd1);

        // Bad SYNC.
        start_pkt();
        send_byte(8'h81);
        check("bad_sync_err", {31'd0, rx_if.rx_error}, 32'd1);
        tick();
        tick();
        check("err_held", {30'd0, rx_if.rx_error, rx_if.rcving}, 32'd3);
        finish_err();
        check("err_through_idle", {30'd0, rx_if.rx_error, rx_if.rcving}, 32'd2);
        rx_if.d_edge = 1'b1;
        tick();
        rx_if.d_edge = 1'b0;
        check("err_cleared", {31'd0, rx_if.rx_error}, 32'd0);

        // Partial byte before eop (continues the packet just started).
        v0 = valid_cnt;
        d0 = done_cnt;
        send_byte(8'h80);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rx_if.eop = 1'b1;
        tick();
        check("partial_err", {31'd0, rx_if.rx_error}, 32'd1);
        tick();
        rx_if.eop = 1'b0;
        tick();
        tick();
        check("partial_nowrite", valid_cnt, v0);
        check("partial_nodone", done_cnt, d0);

        // FIFO full on the first payload byte.
        start_pkt();
        send_byte(8'h80);
        rx_if.fifo_full = 1'b1;
        send_byte(8'hA5);
        check("full_err", {31'd0, rx_if.rx_error}, 32'd1);
        check("full_count", 32'(rx_if.byte_count), 32'd0);
        rx_if.fifo_full = 1'b0;
        finish_err();

        // Overlength: third byte's first strobe in EOP_WAIT.
        start_pkt();
        send_byte(8'h80);
        sb.push_back(8'h11);
        send_byte(8'h11);
        sb.push_back(8'h22);
        send_byte(8'h22);
        check("ovl_no_err_yet", {31'd0, rx_if.rx_error}, 32'd0);
        send_bit(1'b1);
        check("ovl_err", {31'd0, rx_if.rx_error}, 32'd1);
        check("ovl_count", 32'(rx_if.byte_count), 32'd2);
        finish_err();

        // Zero-length payload.
        start_pkt();
        send_byte(8'h80);
        rx_if.eop = 1'b1;
        tick();
        check("zero_len_done", {30'd0, rx_if.rx_packet_done, rx_if.rx_error}, 32'd2);
        tick();
        rx_if.eop = 1'b0;
        tick();

        // Reset mid-RECV.
        d0 = done_cnt;
        start_pkt();
        send_byte(8'h80);
        sb.push_back(8'h77);
        send_byte(8'h77);
        send_bit(1'b1);
        send_bit(1'b1);
        rst = 1'b1;
        tick();
        check("mid_rst_count", 32'(rx_if.byte_count), 32'd0);
        check("mid_rst_byte", {24'd0, rx_if.rx_byte}, 32'd0);
        check("mid_rst_flags", {27'd0, rx_if.rx_byte_valid, rx_if.rx_packet_done, rx_if.rx_error,
                                rx_if.rcving, rx_if.decoder_rearm}, 32'd0);
        rst = 1'b0;
        tick();
        check("mid_rst_nodone", done_cnt, d0);

        // eop and strobe together on a byte boundary.
        start_pkt();
        send_byte(8'h80);
        sb.push_back(8'h5A);
        send_byte(8'h5A);
        rx_if.eop          = 1'b1;
        rx_if.shift_strobe = 1'b1;
        rx_if.d_decoded    = 1'b1;
        tick();
        rx_if.shift_strobe = 1'b0;
        check("eop_wins_done", {30'd0, rx_if.rx_packet_done, rx_if.rx_error}, 32'd2);
        check("eop_wins_count", 32'(rx_if.byte_count), 32'd1);
        tick();
        rx_if.eop = 1'b0;
        tick();
        tick();

        check("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
